counter: RTL and testbench

Parameterizable up-counter over a fixed range [LOWER, UPPER] with an enable, programmable reset/initial value, and selectable wrap-around or saturation at the top. It is a generic utility block; its main user is the RAM-based shift register, where it generates the circular read address (INIT_VALUE = 1, wrap-around enabled).

---
 rtl/counter_pkg.sv | 12 +
 rtl/counter.sv | 51 +++++
 tb/tb_counter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared helpers for the counter utility.
package counter_pkg;

  // Returns the number of bits needed to hold n. The result is never less than 1.
  function automatic int log2(input int n);
    int w;
    w = 1;
    while ((n >> w) != 0) w++;
    return w;
  endfunction

endpackage

// File: rtl/counter.sv
// Up-counter over [LOWER, UPPER]. At the top it either wraps to LOWER or holds at UPPER.
module counter
  import counter_pkg::*;
#(
  parameter int LOWER      = 0,
  parameter int UPPER      = 1,
  parameter int WRAPAROUND = 1,
  parameter int INIT_VALUE = 0,
  localparam int WIDTH     = log2(UPPER)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  output logic             at_max,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] LOWER_W = WIDTH'(LOWER);
  localparam logic [WIDTH-1:0] UPPER_W = WIDTH'(UPPER);
  localparam logic [WIDTH-1:0] INIT_W  = WIDTH'(INIT_VALUE);

  generate
    if (!(LOWER >= 0 && LOWER <= INIT_VALUE && INIT_VALUE <= UPPER)) begin : g_bad_params
      $error("counter: need 0 <= LOWER <= INIT_VALUE <= UPPER");
    end
  endgenerate

  logic [WIDTH-1:0] value_q = INIT_W;
  logic [WIDTH-1:0] value_d;

  // The top-of-range test is done first, so the increment can never overflow.
  always_comb begin
    value_d = value_q;
    if (ena) begin
      if (value_q != UPPER_W) begin
        value_d = value_q + WIDTH'(1);
      end else if (WRAPAROUND != 0) begin
        value_d = LOWER_W;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= INIT_W;
    else     value_q <= value_d;
  end

  assign value  = value_q;
  assign at_max = (value_q == UPPER_W);

endmodule

// File: tb/tb_counter.sv
// Checks several counter configurations against a behavioural model that steps one clock at a time.
module tb_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: 0..5 wrap, init 1   B: 2..4 saturate, init 2   C: 3..3 degenerate
  // D: defaults (0..1)      E: 10..200 wrap, init 100
  logic       rst_a = 1'b1, ena_a = 1'b0, max_a;
  logic       rst_b = 1'b1, ena_b = 1'b0, max_b;
  logic       rst_c = 1'b1, ena_c = 1'b0, max_c;
  logic       rst_d = 1'b1, ena_d = 1'b0, max_d;
  logic       rst_e = 1'b1, ena_e = 1'b0, max_e;
  logic [2:0] val_a, val_b;
  logic [1:0] val_c;
  logic [0:0] val_d;
  logic [7:0] val_e;

  counter #(.LOWER(0), .UPPER(5), .WRAPAROUND(1), .INIT_VALUE(1)) u_a
    (.clk(clk), .rst(rst_a), .ena(ena_a), .at_max(max_a), .value(val_a));
  counter #(.LOWER(2), .UPPER(4), .WRAPAROUND(0), .INIT_VALUE(2)) u_b
    (.clk(clk), .rst(rst_b), .ena(ena_b), .at_max(max_b), .value(val_b));
  counter #(.LOWER(3), .UPPER(3), .WRAPAROUND(1), .INIT_VALUE(3)) u_c
    (.clk(clk), .rst(rst_c), .ena(ena_c), .at_max(max_c), .value(val_c));
  counter u_d
    (.clk(clk), .rst(rst_d), .ena(ena_d), .at_max(max_d), .value(val_d));
  counter #(.LOWER(10), .UPPER(200), .WRAPAROUND(1), .INIT_VALUE(100)) u_e
    (.clk(clk), .rst(rst_e), .ena(ena_e), .at_max(max_e), .value(val_e));

  int errors = 0;
  int checks = 0;
  int m_a = 1, m_b = 2, m_c = 3, m_d = 0, m_e = 100;

  // The counting rules: reset first, then hold, then increment, then wrap or saturate.
  function automatic int step(int v, int lo, int hi, bit wrap, int init, logic ena, logic rst);
    if (rst)       return init;
    if (!ena)      return v;
    if (v < hi)    return v + 1;
    if (wrap)      return lo;
    return hi;
  endfunction

  // Advance one clock: the models take the inputs the DUT samples, and the task returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    m_a = step(m_a, 0, 5, 1'b1, 1, ena_a, rst_a);
    m_b = step(m_b, 2, 4, 1'b0, 2, ena_b, rst_b);
    m_c = step(m_c, 3, 3, 1'b1, 3, ena_c, rst_c);
    m_d = step(m_d, 0, 1, 1'b1, 0, ena_d, rst_d);
    m_e = step(m_e, 10, 200, 1'b1, 100, ena_e, rst_e);
    @(negedge clk);
  endtask

  task automatic test_power_up();
    #1;
    checks++;
    if (val_a !== 3'd1 || val_b !== 3'd2 || val_c !== 2'd3 || val_d !== 1'd0 || val_e !== 8'd100) begin
      errors++;
      $display("FAIL power_up: got a=%0d b=%0d c=%0d d=%0d e=%0d expected 1 2 3 0 100",
               val_a, val_b, val_c, val_d, val_e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    {rst_a, rst_b, rst_c, rst_d, rst_e} = '1;
    {ena_a, ena_b, ena_c, ena_d, ena_e} = '1;
    tick();
    checks++;
    if (val_a !== 3'd1 || val_b !== 3'd2 || val_c !== 2'd3 || val_d !== 1'd0 || val_e !== 8'd100) begin
      errors++;
      $display("FAIL reset_value: got a=%0d b=%0d c=%0d d=%0d e=%0d expected 1 2 3 0 100",
               val_a, val_b, val_c, val_d, val_e);
    end
    checks++;
    if ({max_a, max_b, max_c, max_d, max_e} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_at_max: got %b expected 00100", {max_a, max_b, max_c, max_d, max_e});
    end
    {rst_a, rst_b, rst_c, rst_d, rst_e} = '0;
    {ena_a, ena_b, ena_c, ena_d, ena_e} = '0;
  endtask

  task automatic test_wrap_sequence();
    int exp_seq[12] = '{2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1};
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    ena_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (val_a !== 3'(exp_seq[i]) || max_a !== (exp_seq[i] == 5)) begin
        errors++;
        $display("FAIL wrap_seq[%0d]: got value=%0d at_max=%b expected value=%0d at_max=%b",
                 i, val_a, max_a, exp_seq[i], exp_seq[i] == 5);
      end
    end
    ena_a = 1'b0;
  endtask

  task automatic test_toggle();
    logic ena_pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int   exp_seq[4] = '{2, 2, 3, 3};
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ena_a = ena_pat[i];
      tick();
      checks++;
      if (val_a !== 3'(exp_seq[i])) begin
        errors++;
        $display("FAIL toggle[%0d]: got %0d expected %0d", i, val_a, exp_seq[i]);
      end
    end
    ena_a = 1'b0;
  endtask

  task automatic test_saturate();
    int exp_seq[6] = '{2, 3, 4, 4, 4, 4};
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    ena_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (val_b !== 3'(exp_seq[i]) || max_b !== (exp_seq[i] == 4)) begin
        errors++;
        $display("FAIL saturate[%0d]: got value=%0d at_max=%b expected value=%0d at_max=%b",
                 i, val_b, max_b, exp_seq[i], exp_seq[i] == 4);
      end
      if (i < 5) tick();
    end
    ena_b = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    ena_a = 1'b1;
    repeat (3) tick();
    checks++;
    if (val_a !== 3'd4) begin
      errors++;
      $display("FAIL mid_reset_pre: got %0d expected 4", val_a);
    end
    rst_a = 1'b1;
    tick();
    checks++;
    if (val_a !== 3'd1 || max_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got value=%0d at_max=%b expected value=1 at_max=0", val_a, max_a);
    end
    rst_a = 1'b0;
    tick();
    checks++;
    if (val_a !== 3'd2) begin
      errors++;
      $display("FAIL mid_reset_resume: got %0d expected 2", val_a);
    end
    ena_a = 1'b0;
  endtask

  task automatic test_degenerate();
    for (int i = 0; i < 20; i++) begin
      ena_c = 1'($urandom);
      rst_c = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (val_c !== 2'd3 || max_c !== 1'b1) begin
        errors++;
        $display("FAIL degenerate[%0d]: got value=%0d at_max=%b expected value=3 at_max=1", i, val_c, max_c);
      end
    end
    {rst_c, ena_c} = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      ena_a = 1'($urandom); ena_b = 1'($urandom); ena_c = 1'($urandom);
      ena_d = 1'($urandom); ena_e = ($urandom_range(0, 7) != 0);
      rst_a = ($urandom_range(0, 15) == 0); rst_b = ($urandom_range(0, 15) == 0);
      rst_c = ($urandom_range(0, 15) == 0); rst_d = ($urandom_range(0, 15) == 0);
      rst_e = ($urandom_range(0, 255) == 0);
      tick();
      checks++;
      if (val_a !== 3'(m_a) || max_a !== (m_a == 5) ||
          val_b !== 3'(m_b) || max_b !== (m_b == 4) ||
          val_c !== 2'(m_c) || max_c !== (m_c == 3) ||
          val_d !== 1'(m_d) || max_d !== (m_d == 1) ||
          val_e !== 8'(m_e) || max_e !== (m_e == 200)) begin
        errors++;
        $display("FAIL random[%0d]: got a=%0d/%b b=%0d/%b c=%0d/%b d=%0d/%b e=%0d/%b expected a=%0d b=%0d c=%0d d=%0d e=%0d",
                 i, val_a, max_a, val_b, max_b, val_c, max_c, val_d, max_d, val_e, max_e,
                 m_a, m_b, m_c, m_d, m_e);
      end
    end
  endtask

  initial begin
    test_power_up();
    test_reset();
    test_wrap_sequence();
    test_toggle();
    test_saturate();
    test_reset_mid_count();
    test_degenerate();
    test_reset();
    m_a = 1; m_b = 2; m_c = 3; m_d = 0; m_e = 100;
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
